sysid_check_ctrl: RTL and testbench

- Boot-time controller that sequences reads of the system-ID Avalon-MM slave (address 0 = system ID, address 1 = build timestamp).
- Captures both words and checks them against expected values, with bounded retries.
- Reports pass/fail to the boot/reset-release logic.
- Sits between the reset/boot sequencer and the sysid control_slave; it is that slave's sole master.

---
 rtl/sysid_check_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_ctrl.sv
// Boot-time checker for the system-ID slave: reads ID and timestamp, checks them, retries on failure.
// Optional SYSID_CHECK_AUTOSTART_EN: the first cycle after reset release acts as an implicit start.
module sysid_check_ctrl #(
   parameter logic [31:0] EXPECTED_ID   = 32'h0000_0000,
   parameter logic [31:0] MIN_TIMESTAMP = 32'd0,
   parameter int unsigned READ_LATENCY  = 1,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        result_valid,
   output logic        pass,
   output logic        mismatch_id,
   output logic        stale_ts,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic [3:0]  retry_count
);

   localparam logic [2:0] Lat  = READ_LATENCY[2:0];
   localparam logic [3:0] MaxR = MAX_RETRIES[3:0];

   typedef enum logic [2:0] {
      StIdle,
      StRdId,
      StWaitId,
      StRdTs,
      StWaitTs,
      StCheck,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  lat_cnt_q, lat_cnt_d;
   logic        addr_q, addr_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        valid_q, valid_d;
   logic        pass_q, pass_d;
   logic        mism_q, mism_d;
   logic        stale_q, stale_d;
   logic [3:0]  retry_q, retry_d;
   logic        start_eff;
   logic        chk_mism, chk_stale;

`ifdef SYSID_CHECK_AUTOSTART_EN
   logic auto_q, auto_d;

   // Armed by reset, consumed by the first cycle out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         auto_q <= 1'b1;
      end else begin
         auto_q <= auto_d;
      end
   end

   always_comb begin
      auto_d    = 1'b0;
      start_eff = start | auto_q;
   end
`else
   always_comb begin
      start_eff = start;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         lat_cnt_q <= 3'd0;
         addr_q    <= 1'b0;
         id_q      <= 32'd0;
         ts_q      <= 32'd0;
         valid_q   <= 1'b0;
         pass_q    <= 1'b0;
         mism_q    <= 1'b0;
         stale_q   <= 1'b0;
         retry_q   <= 4'd0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         addr_q    <= addr_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         valid_q   <= valid_d;
         pass_q    <= pass_d;
         mism_q    <= mism_d;
         stale_q   <= stale_d;
         retry_q   <= retry_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      addr_d    = addr_q;
      id_d      = id_q;
      ts_d      = ts_q;
      valid_d   = valid_q;
      pass_d    = pass_q;
      mism_d    = mism_q;
      stale_d   = stale_q;
      retry_d   = retry_q;
      chk_mism  = (id_q != EXPECTED_ID);
      chk_stale = (ts_q < MIN_TIMESTAMP);

      unique case (state_q)
         StIdle: begin
            if (start_eff) begin
               state_d = StRdId;
               addr_d  = 1'b0;
               valid_d = 1'b0;
               pass_d  = 1'b0;
               mism_d  = 1'b0;
               stale_d = 1'b0;
               retry_d = 4'd0;
            end
         end
         StRdId: begin
            lat_cnt_d = 3'd0;
            if (Lat == 3'd0) begin
               id_d    = sysid_readdata;
               addr_d  = 1'b1;
               state_d = StRdTs;
            end else begin
               state_d = StWaitId;
            end
         end
         StWaitId: begin
            // Counter value after this cycle's increment is the elapsed latency.
            lat_cnt_d = lat_cnt_q + 3'd1;
            if (lat_cnt_d == Lat) begin
               id_d    = sysid_readdata;
               addr_d  = 1'b1;
               state_d = StRdTs;
            end
         end
         StRdTs: begin
            lat_cnt_d = 3'd0;
            if (Lat == 3'd0) begin
               ts_d    = sysid_readdata;
               state_d = StCheck;
            end else begin
               state_d = StWaitTs;
            end
         end
         StWaitTs: begin
            lat_cnt_d = lat_cnt_q + 3'd1;
            if (lat_cnt_d == Lat) begin
               ts_d    = sysid_readdata;
               state_d = StCheck;
            end
         end
         StCheck: begin
            mism_d  = chk_mism;
            stale_d = chk_stale;
            if (!chk_mism && !chk_stale) begin
               pass_d  = 1'b1;
               valid_d = 1'b1;
               state_d = StDone;
            end else if (retry_q < MaxR) begin
               retry_d = retry_q + 4'd1;
               addr_d  = 1'b0;
               state_d = StRdId;
            end else begin
               pass_d  = 1'b0;
               valid_d = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      sysid_address   = addr_q;
      sysid_read      = (state_q == StRdId) || (state_q == StRdTs);
      busy            = (state_q == StRdId) || (state_q == StWaitId) || (state_q == StRdTs) ||
                        (state_q == StWaitTs) || (state_q == StCheck);
      done            = (state_q == StDone);
      result_valid    = valid_q;
      pass            = pass_q;
      mismatch_id     = mism_q;
      stale_ts        = stale_q;
      id_value        = id_q;
      timestamp_value = ts_q;
      retry_count     = retry_q;
   end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: three configurations, transaction-level model checked every cycle,
// plus directed literal expectations. Honours SYSID_CHECK_AUTOSTART_EN when defined.
module tb_sysid_check_ctrl;

   localparam int ND = 3;
   localparam logic [31:0] P_EXP [ND] = '{32'h0000_0000, 32'hCAFE_0001, 32'h0000_0000};
   localparam logic [31:0] P_MIN [ND] = '{32'h0000_0000, 32'h6000_0000, 32'h0000_0100};
   localparam int          P_LAT [ND] = '{1, 1, 0};
   localparam int          P_MAX [ND] = '{3, 3, 0};
`ifdef SYSID_CHECK_AUTOSTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct packed {
      int          na;
      logic        pass;
      logic        mm;
      logic        stale;
      logic [31:0] idv;
      logic [31:0] tsv;
   } txn_t;

   logic        clock;
   logic        rst    [ND];
   logic        st     [ND];
   logic        addr_o [ND];
   logic        rd_o   [ND];
   logic        busy_o [ND];
   logic        done_o [ND];
   logic        rv_o   [ND];
   logic        pass_o [ND];
   logic        mm_o   [ND];
   logic        stale_o[ND];
   logic [31:0] id_o   [ND];
   logic [31:0] ts_o   [ND];
   logic [3:0]  rc_o   [ND];
   logic [31:0] sl_dat [ND];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   sysid_check_ctrl u_def (
      .clock(clock), .reset(rst[0]), .start(st[0]), .sysid_address(addr_o[0]),
      .sysid_read(rd_o[0]), .sysid_readdata(sl_dat[0]), .busy(busy_o[0]), .done(done_o[0]),
      .result_valid(rv_o[0]), .pass(pass_o[0]), .mismatch_id(mm_o[0]), .stale_ts(stale_o[0]),
      .id_value(id_o[0]), .timestamp_value(ts_o[0]), .retry_count(rc_o[0])
   );

   sysid_check_ctrl #(
      .EXPECTED_ID(32'hCAFE_0001), .MIN_TIMESTAMP(32'h6000_0000), .READ_LATENCY(1),
      .MAX_RETRIES(3)
   ) u_prm (
      .clock(clock), .reset(rst[1]), .start(st[1]), .sysid_address(addr_o[1]),
      .sysid_read(rd_o[1]), .sysid_readdata(sl_dat[1]), .busy(busy_o[1]), .done(done_o[1]),
      .result_valid(rv_o[1]), .pass(pass_o[1]), .mismatch_id(mm_o[1]), .stale_ts(stale_o[1]),
      .id_value(id_o[1]), .timestamp_value(ts_o[1]), .retry_count(rc_o[1])
   );

   sysid_check_ctrl #(
      .EXPECTED_ID(32'h0000_0000), .MIN_TIMESTAMP(32'h0000_0100), .READ_LATENCY(0),
      .MAX_RETRIES(0)
   ) u_l0 (
      .clock(clock), .reset(rst[2]), .start(st[2]), .sysid_address(addr_o[2]),
      .sysid_read(rd_o[2]), .sysid_readdata(sl_dat[2]), .busy(busy_o[2]), .done(done_o[2]),
      .result_valid(rv_o[2]), .pass(pass_o[2]), .mismatch_id(mm_o[2]), .stale_ts(stale_o[2]),
      .id_value(id_o[2]), .timestamp_value(ts_o[2]), .retry_count(rc_o[2])
   );

   // Slave: the n-th read at an address returns entry n of that address's table.
   logic [31:0] id_seq [ND][4];
   logic [31:0] ts_seq [ND][4];
   int n_id[ND], n_ts[ND], gen_req[ND], gen_seen[ND], sl_ix[ND];

   initial begin
      for (int d = 0; d < ND; d++) begin
         gen_req[d] = 0;
      end
   end

   always @(posedge clock) begin
      for (int d = 0; d < ND; d++) begin
         if (rst[d] || gen_req[d] != gen_seen[d]) begin
            n_id[d]     <= 0;
            n_ts[d]     <= 0;
            gen_seen[d] <= gen_req[d];
         end else if (rd_o[d] === 1'b1) begin
            if (addr_o[d]) n_ts[d] <= n_ts[d] + 1;
            else n_id[d] <= n_id[d] + 1;
         end
      end
   end

   always_comb begin
      for (int d = 0; d < ND; d++) begin
         sl_ix[d] = addr_o[d] ? n_ts[d] : n_id[d];
         if (rd_o[d] !== 1'b1) sl_ix[d] = sl_ix[d] - 1;
         if (sl_ix[d] < 0) sl_ix[d] = 0;
         if (sl_ix[d] > 3) sl_ix[d] = 3;
         sl_dat[d] = addr_o[d] ? ts_seq[d][sl_ix[d]] : id_seq[d][sl_ix[d]];
      end
   end

   // Model: an accepted start fixes the whole transaction from the slave tables.
   logic act [ND];
   logic pend[ND];
   int   ks  [ND];
   txn_t mt  [ND];
   int   strobes[ND];

   function automatic txn_t calc(int d);
      txn_t t;
      bit   fin;
      t   = '0;
      fin = 1'b0;
      for (int a = 0; a < 4; a++) begin
         if (!fin && a <= P_MAX[d]) begin
            t.idv   = id_seq[d][a];
            t.tsv   = ts_seq[d][a];
            t.mm    = (t.idv != P_EXP[d]);
            t.stale = (t.tsv < P_MIN[d]);
            t.na    = a + 1;
            fin     = !t.mm && !t.stale;
         end
      end
      t.pass = !t.mm && !t.stale;
      return t;
   endfunction

   function automatic int per(int d);
      return 3 + 2 * P_LAT[d];
   endfunction

   function automatic int kdone(int d);
      return ks[d] + 4 + 2 * P_LAT[d] + (mt[d].na - 1) * per(d);
   endfunction

   function automatic int offp(int d, int c);
      return (c - ks[d] - 1) % per(d);
   endfunction

   function automatic logic e_busy(int d, int c);
      return act[d] && c > ks[d] && c < kdone(d);
   endfunction

   function automatic logic e_read(int d, int c);
      return e_busy(d, c) && (offp(d, c) == 0 || offp(d, c) == 1 + P_LAT[d]);
   endfunction

   function automatic logic e_addr(int d, int c);
      if (e_busy(d, c)) return offp(d, c) >= 1 + P_LAT[d];
      return act[d];
   endfunction

   always @(posedge clock) begin
      cyc <= cyc + 1;
      for (int d = 0; d < ND; d++) begin
         if (rst[d]) begin
            act[d]  <= 1'b0;
            pend[d] <= 1'b1;
         end else begin
            pend[d] <= 1'b0;
            if ((st[d] || (AUTO && pend[d])) && (!act[d] || cyc > kdone(d))) begin
               act[d] <= 1'b1;
               ks[d]  <= cyc;
               mt[d]  <= calc(d);
            end
         end
      end
   end

   task automatic chk(string nm, int d, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, a, e);
      end
   endtask

   initial begin
      for (int d = 0; d < ND; d++) strobes[d] = 0;
   end

   always @(negedge clock) begin
      if (chk_en) begin
         for (int d = 0; d < ND; d++) begin
            if (rd_o[d] === 1'b1) strobes[d] <= strobes[d] + 1;
            chk("busy", d, busy_o[d], e_busy(d, cyc));
            chk("read", d, rd_o[d], e_read(d, cyc));
            chk("done", d, done_o[d], act[d] && cyc == kdone(d));
            chk("addr", d, addr_o[d], e_addr(d, cyc));
            if (act[d] && cyc >= kdone(d)) begin
               chk("rv", d, rv_o[d], 1);
               chk("pass", d, pass_o[d], mt[d].pass);
               chk("mism", d, mm_o[d], mt[d].mm);
               chk("stale", d, stale_o[d], mt[d].stale);
               chk("retry", d, rc_o[d], mt[d].na - 1);
               chk("idv", d, id_o[d], mt[d].idv);
               chk("tsv", d, ts_o[d], mt[d].tsv);
            end else if (act[d]) begin
               chk("rv_busy", d, rv_o[d], 0);
               chk("pass_busy", d, pass_o[d], 0);
            end else begin
               chk("rv_idle", d, rv_o[d], 0);
               chk("pass_idle", d, pass_o[d], 0);
               chk("mism_idle", d, mm_o[d], 0);
               chk("stale_idle", d, stale_o[d], 0);
               chk("retry_idle", d, rc_o[d], 0);
               chk("idv_idle", d, id_o[d], 0);
               chk("tsv_idle", d, ts_o[d], 0);
            end
         end
      end
   end

   task automatic cyc_wait(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_seq(int d, logic [31:0] i0, logic [31:0] i1, logic [31:0] t0,
                          logic [31:0] t1);
      id_seq[d][0] = i0;
      ts_seq[d][0] = t0;
      for (int a = 1; a < 4; a++) begin
         id_seq[d][a] = i1;
         ts_seq[d][a] = t1;
      end
      gen_req[d] = gen_req[d] + 1;
      cyc_wait(2);
   endtask

   // Called just after a rising edge; start is high for exactly the current cycle.
   task automatic run(int d, int lim, output int lat, output int nstr);
      int k, s0;
      k     = cyc;
      s0    = strobes[d];
      st[d] = 1'b1;
      cyc_wait(1);
      st[d] = 1'b0;
      lat   = -1;
      for (int i = 0; i < lim && lat < 0; i++) begin
         @(negedge clock);
         if (done_o[d] === 1'b1) lat = cyc - k;
      end
      chk("done_seen", d, lat >= 0, 1);
      cyc_wait(1);
      nstr = strobes[d] - s0;
   endtask

   int lat, nstr, s0;

   initial begin
      for (int d = 0; d < ND; d++) begin
         st[d]  = 1'b0;
         rst[d] = 1'b1;
      end
      set_seq(0, 32'h0, 32'h0, 32'h52FA_2B9C, 32'h52FA_2B9C);
      set_seq(1, 32'h0, 32'h0, 32'h6000_0010, 32'h6000_0010);
      set_seq(2, 32'h0, 32'h0, 32'h0000_0200, 32'h0000_0200);
      chk_en = 1'b1;
      chk("reset_busy", 0, busy_o[0], 0);
      chk("reset_id", 0, id_o[0], 0);
      for (int d = 0; d < ND; d++) rst[d] = 1'b0;
      cyc_wait(40);

      // Defaults, clean check.
      set_seq(0, 32'h0, 32'h0, 32'h52FA_2B9C, 32'h52FA_2B9C);
      run(0, 50, lat, nstr);
      chk("t1_lat", 0, lat, 6);
      chk("t1_strobes", 0, nstr, 2);
      chk("t1_pass", 0, pass_o[0], 1);
      chk("t1_rv", 0, rv_o[0], 1);
      chk("t1_id", 0, id_o[0], 32'h0);
      chk("t1_ts", 0, ts_o[0], 32'h52FA_2B9C);
      chk("t1_retry", 0, rc_o[0], 0);

      // ID never matches: all retries consumed.
      set_seq(1, 32'h0, 32'h0, 32'h6000_0010, 32'h6000_0010);
      run(1, 60, lat, nstr);
      chk("t2_lat", 1, lat, 21);
      chk("t2_strobes", 1, nstr, 8);
      chk("t2_pass", 1, pass_o[1], 0);
      chk("t2_mism", 1, mm_o[1], 1);
      chk("t2_stale", 1, stale_o[1], 0);
      chk("t2_retry", 1, rc_o[1], 3);

      // Stale timestamp on the first attempt only.
      set_seq(1, 32'hCAFE_0001, 32'hCAFE_0001, 32'h1000_0000, 32'h6000_0010);
      run(1, 60, lat, nstr);
      chk("t3_lat", 1, lat, 11);
      chk("t3_strobes", 1, nstr, 4);
      chk("t3_pass", 1, pass_o[1], 1);
      chk("t3_retry", 1, rc_o[1], 1);
      chk("t3_ts", 1, ts_o[1], 32'h6000_0010);

      // Zero read latency.
      set_seq(2, 32'h0, 32'h0, 32'h0000_0200, 32'h0000_0200);
      run(2, 30, lat, nstr);
      chk("t4_lat", 2, lat, 4);
      chk("t4_strobes", 2, nstr, 2);
      chk("t4_pass", 2, pass_o[2], 1);

      // No retries allowed: a stale timestamp fails at once.
      set_seq(2, 32'h0, 32'h0, 32'h0000_0050, 32'h0000_0050);
      run(2, 30, lat, nstr);
      chk("t5_lat", 2, lat, 4);
      chk("t5_pass", 2, pass_o[2], 0);
      chk("t5_stale", 2, stale_o[2], 1);
      chk("t5_retry", 2, rc_o[2], 0);

      // Start during the DONE cycle is dropped.
      set_seq(2, 32'h0, 32'h0, 32'h0000_0200, 32'h0000_0200);
      s0    = strobes[2];
      st[2] = 1'b1;
      cyc_wait(1);
      st[2] = 1'b0;
      cyc_wait(3);
      chk("t6_done", 2, done_o[2], 1);
      st[2] = 1'b1;
      cyc_wait(1);
      st[2] = 1'b0;
      cyc_wait(8);
      chk("t6_strobes", 2, strobes[2] - s0, 2);

      // Reset in WAIT_TS with a start pulse while busy.
      set_seq(0, 32'h0, 32'h0, 32'h52FA_2B9C, 32'h52FA_2B9C);
      st[0] = 1'b1;
      cyc_wait(1);
      st[0] = 1'b0;
      cyc_wait(1);
      st[0] = 1'b1;
      cyc_wait(1);
      st[0] = 1'b0;
      cyc_wait(1);
      chk("t7_busy", 0, busy_o[0], 1);
      chk("t7_addr", 0, addr_o[0], 1);
      rst[0] = 1'b1;
      cyc_wait(1);
      rst[0] = 1'b0;
      chk("t7_busy0", 0, busy_o[0], 0);
      chk("t7_rv0", 0, rv_o[0], 0);
      chk("t7_ts0", 0, ts_o[0], 0);
      chk("t7_addr0", 0, addr_o[0], 0);
      chk("t7_retry0", 0, rc_o[0], 0);
      s0 = strobes[0];
      cyc_wait(10);
      chk("t7_strobes", 0, strobes[0] - s0, AUTO ? 2 : 0);

      cyc_wait(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
